hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Downstream stage of the serial extended-Hamming (16,11) SECDED encoder.
- Deserialises one 16-bit code block arriving one bit per clock, with bit position 0 first.
- Computes the syndrome and overall parity, corrects single-bit errors and flags double errors.
- Re-serialises the 11 recovered data bits toward the consumer with a valid/ready handshake.

Parameters:
- FWD_UNCORR, default 1: 1 = forward data bits of a double-error block unchanged (err_double still flagged); 0 = discard that block's data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial code bit; position index equals arrival order 0..15
- din_valid  in  1  din carries a bit this cycle
- din_ready  out  1  decoder accepts a bit this cycle
- dout  out  1  serial recovered data bit
- dout_valid  out  1  dout valid
- dout_ready  in  1  consumer accepts dout this cycle
- stat_valid  out  1  one-cycle pulse; the status outputs below are valid for this block
- err_corr  out  1  single error corrected (valid with stat_valid)
- err_double  out  1  uncorrectable double error (valid with stat_valid)
- err_pos  out  4  corrected bit position (valid with stat_valid and err_corr, else 0)

Behaviour:
- Code layout (fixed, matches encoder):
  - position 0 = overall parity;
  - positions 1, 2, 4, 8 = Hamming parity;
  - data positions in output order = 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15.
- Reset, asynchronous, any state: state=RECV, bit count=0, syndrome=0, parity=0, block buffer=0, data index=0.
  - Outputs at reset: din_ready=1, dout=0, dout_valid=0, stat_valid=0, err_corr=0, err_double=0, err_pos=0.
  - Reset mid-block discards the partial block; no status pulse.
- RECV:
  - din_ready=1.
  - Each cycle with din_valid=1: buf[cnt] <= din; syn <= syn ^ (din ? cnt : 0); par <= par ^ din; cnt <= cnt+1 (4-bit, wraps 15->0).
  - Accepting the bit at cnt=15 moves to EVAL next cycle.
  - A cycle with din_valid=0 holds all state.
- EVAL (exactly 1 cycle):
  - din_ready=0.
  - Uses final syn/par including bit 15.
  - Classification:
    - syn=0, par=0: clean; err_corr=0, err_double=0.
    - par=1: single error at position syn; syn=0 means position 0 itself. Flip buf[syn]; err_corr=1, err_pos=syn.
    - syn!=0, par=0: double error; err_double=1, buffer unchanged.
  - stat_valid pulses high this cycle; err_* hold their values until the next EVAL or reset.
  - Clear syn, par, cnt.
  - Next state: SEND, except double error with FWD_UNCORR=0, which returns directly to RECV.
- SEND:
  - din_ready=0, dout_valid=1.
  - dout = corrected buf[DATA_POS[k]]; k starts at 0.
  - On dout_valid and dout_ready: k <= k+1.
  - On the handshake at k=10: k <= 0, dout_valid falls, state returns to RECV next cycle.
  - dout_ready=0 holds dout and dout_valid stable; no bit is dropped or repeated.
- Latency: first data bit presented 2 cycles after the cycle in which bit 15 was accepted (EVAL, then SEND).
- Throughput: 16 + 1 + 11 cycles per block minimum. No input overlap; din_ready gates the upstream.
- Positions 1, 2, 4, 8 and 0 are never output; errors corrected there only set err_corr/err_pos.

Decomposition:
- Package hamming_pkg holds:
  - BLOCK_LEN=16, DATA_LEN=11;
  - DATA_POS constant array {3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
  - state enum {RECV, EVAL, SEND};
  - a syndrome-width constant (4).
- One natural sub-module: hamming_syndrome_acc.
  - Running syndrome/parity accumulator with inputs bit, index, enable, clear.
  - Outputs syn[3:0] and par; reusable by any future block decoder.

Test Plan:
- All-zero codeword, dout_ready=1 -> stat_valid with err_corr=0, err_double=0; 11 zero bits out; first dout_valid 2 cycles after bit 15.
- Codeword bits {0, 1, 2, 3} = 1 (data bit 0 = 1), no error -> clean status; dout sequence 1,0,0,0,0,0,0,0,0,0,0.
- Same codeword with bit 5 flipped -> err_corr=1, err_pos=5; output corrected to 1 followed by ten 0s.
- All-zero codeword with bit 0 flipped -> err_corr=1, err_pos=0; output all zeros.
- All-zero codeword with bits 3 and 5 flipped -> err_double=1, err_corr=0; FWD_UNCORR=1 outputs 1,1,0,...; FWD_UNCORR=0 sends no dout and din_ready returns 1 the cycle after EVAL.
- Backpressure and reset:
  - dout_ready toggled 0/1 randomly -> exactly 11 bits delivered in order, each held stable while stalled.
  - rst asserted after 7 input bits, then a clean block -> only the second block is decoded, with correct status.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared constants and types for the extended-Hamming (16,11)
//               SECDED serial decoder. It defines the code block geometry,
//               the order in which data positions are sent out, and the
//               decoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int BLOCK_LEN = 16;
    localparam int DATA_LEN  = 11;
    localparam int SYN_W     = 4;

    // Code positions that carry data, listed in the order they are sent out.
    // Position 0 holds the overall parity and positions 1/2/4/8 hold the
    // Hamming parity, so none of these appear here.
    localparam logic [SYN_W-1:0] DATA_POS [0:DATA_LEN-1] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        RECV = 2'd0,
        EVAL = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome_acc.sv
`default_nettype none
// ============================================================================
// Module      : hamming_syndrome_acc
// Description : Running syndrome and overall-parity accumulator for a
//               Hamming code received one bit per cycle. The syndrome is the
//               XOR of the indices of all '1' bits. The parity is the XOR of
//               all bits.
// Ports       : clk     - rising-edge clock
//               rst     - asynchronous active-high reset
//               i_bit   - received code bit
//               i_index - code position of i_bit
//               i_en    - fold i_bit into the running values this cycle
//               i_clr   - restart accumulation; has priority over i_en
//               o_syn   - accumulated syndrome
//               o_par   - accumulated overall parity
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_syndrome_acc
    import hamming_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit,
    input  logic [SYN_W-1:0] i_index,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [SYN_W-1:0] o_syn,
    output logic             o_par
);

    logic [SYN_W-1:0] r_syn;
    logic             r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syn <= '0;
            r_par <= 1'b0;
        end else if (i_clr) begin
            r_syn <= '0;
            r_par <= 1'b0;
        end else if (i_en) begin
            r_syn <= r_syn ^ (i_bit ? i_index : '0);
            r_par <= r_par ^ i_bit;
        end
    end

    assign o_syn = r_syn;
    assign o_par = r_par;

endmodule
`default_nettype wire

// File: rtl/hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decoder
// Description : Serial extended-Hamming (16,11) SECDED decoder. It collects
//               a 16-bit code block one bit per cycle, with position 0 first.
//               It then corrects a single error or flags a double error, and
//               sends the 11 data bits out over a valid/ready handshake.
// Parameters  : FWD_UNCORR - 1: forward the data of a double-error block
//                            unchanged; 0: drop that block's data
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               din        - serial code bit (in)
//               din_valid  - din carries a bit (in)
//               din_ready  - decoder accepts a bit (out)
//               dout       - serial recovered data bit (out)
//               dout_valid - dout valid (out)
//               dout_ready - consumer accepts dout (in)
//               stat_valid - one-cycle status pulse per block (out)
//               err_corr   - single error corrected (out)
//               err_double - uncorrectable double error (out)
//               err_pos    - corrected position, 0 when no correction (out)
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter bit FWD_UNCORR = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             stat_valid,
    output logic             err_corr,
    output logic             err_double,
    output logic [SYN_W-1:0] err_pos
);

    localparam logic [SYN_W-1:0] c_CNT_LAST = SYN_W'(BLOCK_LEN - 1);
    localparam logic [3:0]       c_K_LAST   = 4'(DATA_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYN_W-1:0]       r_cnt;
    logic [BLOCK_LEN-1:0]   r_buf;
    logic [3:0]             r_k;
    logic                   r_err_corr;
    logic                   r_err_double;
    logic [SYN_W-1:0]       r_err_pos;

    logic [SYN_W-1:0]       w_syn;
    logic                   w_par;
    logic                   w_accept;
    logic                   w_take;
    logic                   w_single;
    logic                   w_double;

    assign w_accept = (r_state == RECV) && din_valid;
    assign w_take   = (r_state == SEND) && dout_ready;

    // An odd overall parity always means a single error, located at w_syn.
    // A zero syndrome means the error is in the parity bit itself.
    // An even parity with a non-zero syndrome can only be a double error.
    assign w_single = w_par;
    assign w_double = !w_par && (w_syn != '0);

    hamming_syndrome_acc u_syn_acc (
        .clk     (clk),
        .rst     (rst),
        .i_bit   (din),
        .i_index (r_cnt),
        .i_en    (w_accept),
        .i_clr   (r_state == EVAL),
        .o_syn   (w_syn),
        .o_par   (w_par)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RECV: begin
                if (w_accept && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (w_double && (FWD_UNCORR == 1'b0)) begin
                    w_state_nxt = RECV;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_take && (r_k == c_K_LAST)) begin
                    w_state_nxt = RECV;
                end
            end
            default: w_state_nxt = RECV;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The status outputs come straight from the classifier
    // during EVAL, so they are valid with stat_valid. After EVAL they show
    // the stored copy of that result.
    // ------------------------------------------------------------------
    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = 1'b0;
        stat_valid = 1'b0;
        err_corr   = r_err_corr;
        err_double = r_err_double;
        err_pos    = r_err_pos;
        case (r_state)
            RECV: din_ready = 1'b1;
            EVAL: begin
                stat_valid = 1'b1;
                err_corr   = w_single;
                err_double = w_double;
                err_pos    = w_single ? w_syn : '0;
            end
            SEND: begin
                dout_valid = 1'b1;
                dout       = r_buf[DATA_POS[r_k]];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: block buffer, bit counter, output index, stored status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_buf        <= '0;
            r_k          <= '0;
            r_err_corr   <= 1'b0;
            r_err_double <= 1'b0;
            r_err_pos    <= '0;
        end else begin
            case (r_state)
                RECV: begin
                    if (w_accept) begin
                        r_buf[r_cnt] <= din;
                        r_cnt        <= r_cnt + 4'd1;
                    end
                end
                EVAL: begin
                    r_cnt        <= '0;
                    r_err_corr   <= w_single;
                    r_err_double <= w_double;
                    r_err_pos    <= w_single ? w_syn : '0;
                    if (w_single) begin
                        r_buf[w_syn] <= ~r_buf[w_syn];
                    end
                end
                SEND: begin
                    if (w_take) begin
                        r_k <= (r_k == c_K_LAST) ? 4'd0 : r_k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_decoder
// Description : Directed self-checking bench for hamming_decoder. Instance
//               dut forwards double-error data and instance dut_nf drops it.
//               Both instances share every input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       dout_ready;

    logic       din_ready, dout, dout_valid, stat_valid, err_corr, err_double;
    logic [3:0] err_pos;
    logic       din_ready_nf, dout_nf, dout_valid_nf, stat_valid_nf;
    logic       err_corr_nf, err_double_nf;
    logic [3:0] err_pos_nf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hamming_decoder #(.FWD_UNCORR(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .stat_valid(stat_valid),
        .err_corr(err_corr), .err_double(err_double), .err_pos(err_pos)
    );

    hamming_decoder #(.FWD_UNCORR(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_nf), .dout(dout_nf), .dout_valid(dout_valid_nf),
        .dout_ready(dout_ready), .stat_valid(stat_valid_nf),
        .err_corr(err_corr_nf), .err_double(err_double_nf), .err_pos(err_pos_nf)
    );

    task automatic do_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Feed one code block, then check the EVAL status and the first SEND cycle.
    task automatic send_block(input logic [15:0] cw, input logic exp_corr,
                              input logic exp_dbl, input logic [3:0] exp_pos,
                              input logic exp_send, input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_vec++;
            if (din_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s din_ready at bit %0d: got %b want 1", name, i, din_ready);
            end
            n_vec++;
            if (stat_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s early stat_valid at bit %0d: got %b want 0", name, i, stat_valid);
            end
            din = cw[i];
            din_valid = 1'b1;
        end
        @(negedge clk);
        din_valid = 1'b0;
        din = 1'b0;
        n_vec++;
        if ({stat_valid, err_corr, err_double, err_pos, din_ready, dout_valid} !==
            {1'b1, exp_corr, exp_dbl, exp_pos, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL %s eval status {sv,corr,dbl,pos,rdy,dv}: got %b%b%b_%h_%b%b want 1%b%b_%h_00",
                     name, stat_valid, err_corr, err_double, err_pos, din_ready, dout_valid,
                     exp_corr, exp_dbl, exp_pos);
        end
        n_vec++;
        if ({stat_valid_nf, err_corr_nf, err_double_nf, err_pos_nf} !==
            {1'b1, exp_corr, exp_dbl, exp_pos}) begin
            n_err++;
            $display("FAIL %s eval status nf: got %b%b%b_%h want 1%b%b_%h", name, stat_valid_nf,
                     err_corr_nf, err_double_nf, err_pos_nf, exp_corr, exp_dbl, exp_pos);
        end
        @(negedge clk);
        n_vec++;
        if ({stat_valid, dout_valid} !== {1'b0, exp_send}) begin
            n_err++;
            $display("FAIL %s post-eval {stat_valid,dout_valid}: got %b%b want 0%b",
                     name, stat_valid, dout_valid, exp_send);
        end
        n_vec++;
        if ({err_corr, err_double, err_pos} !== {exp_corr, exp_dbl, exp_pos}) begin
            n_err++;
            $display("FAIL %s status hold: got %b%b_%h want %b%b_%h", name, err_corr,
                     err_double, err_pos, exp_corr, exp_dbl, exp_pos);
        end
    endtask

    // Collect 11 data bits. exp[k] is the k-th bit out. Starts in the first SEND cycle.
    task automatic recv_block(input logic [10:0] exp, input bit rand_ready, input string name);
        int   n = 0;
        bit   stalled = 0;
        logic held = 1'b0;
        logic rdy;
        for (int c = 0; c < 300 && n < 11; c++) begin
            if (c > 0) @(negedge clk);
            if (stalled) begin
                n_vec++;
                if ({dout_valid, dout} !== {1'b1, held}) begin
                    n_err++;
                    $display("FAIL %s stall hold bit %0d: got v=%b d=%b want v=1 d=%b",
                             name, n, dout_valid, dout, held);
                end
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = rdy;
            if (dout_valid && rdy) begin
                n_vec++;
                if (dout !== exp[n]) begin
                    n_err++;
                    $display("FAIL %s data bit %0d: got %b want %b", name, n, dout, exp[n]);
                end
                n++;
                stalled = 0;
            end else if (dout_valid) begin
                stalled = 1;
                held = dout;
            end
        end
        n_vec++;
        if (n != 11) begin
            n_err++;
            $display("FAIL %s bits delivered: got %0d want 11", name, n);
        end
        @(negedge clk);
        dout_ready = 1'b0;
        n_vec++;
        if ({dout_valid, din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s end of send {dout_valid,din_ready}: got %b%b want 01",
                     name, dout_valid, din_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({din_ready, dout, dout_valid, stat_valid, err_corr, err_double, err_pos} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            n_err++;
            $display("FAIL reset outputs: got %b%b%b%b%b%b_%h want 100000_0", din_ready, dout,
                     dout_valid, stat_valid, err_corr, err_double, err_pos);
        end
        n_vec++;
        if ({din_ready_nf, dout_nf, dout_valid_nf, stat_valid_nf, err_corr_nf, err_double_nf,
             err_pos_nf} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            n_err++;
            $display("FAIL reset outputs nf: got %b%b%b%b%b%b_%h want 100000_0", din_ready_nf,
                     dout_nf, dout_valid_nf, stat_valid_nf, err_corr_nf, err_double_nf, err_pos_nf);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean();
        do_reset();
        send_block(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, "zero");
        recv_block(11'h000, 1'b0, "zero");
        send_block(16'h000F, 1'b0, 1'b0, 4'd0, 1'b1, "d0");
        recv_block(11'h001, 1'b0, "d0");
    endtask

    task automatic test_single();
        do_reset();
        send_block(16'h002F, 1'b1, 1'b0, 4'd5, 1'b1, "flip5");
        recv_block(11'h001, 1'b0, "flip5");
        send_block(16'h0001, 1'b1, 1'b0, 4'd0, 1'b1, "flip0");
        recv_block(11'h000, 1'b0, "flip0");
    endtask

    task automatic test_double();
        do_reset();
        send_block(16'h0028, 1'b0, 1'b1, 4'd0, 1'b1, "dbl");
        n_vec++;
        if ({din_ready_nf, dout_valid_nf} !== 2'b10) begin
            n_err++;
            $display("FAIL dbl nf after eval {din_ready,dout_valid}: got %b%b want 10",
                     din_ready_nf, dout_valid_nf);
        end
        recv_block(11'h003, 1'b0, "dbl");
        n_vec++;
        if (dout_valid_nf !== 1'b0) begin
            n_err++;
            $display("FAIL dbl nf dout_valid: got %b want 0", dout_valid_nf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_block(16'h8448, 1'b0, 1'b0, 4'd0, 1'b1, "b2b_clean");
        recv_block(11'h425, 1'b1, "b2b_clean");
        send_block(16'h8548, 1'b1, 1'b0, 4'd8, 1'b1, "b2b_pos8");
        recv_block(11'h425, 1'b1, "b2b_pos8");
        send_block(16'h0448, 1'b1, 1'b0, 4'd15, 1'b1, "b2b_pos15");
        recv_block(11'h425, 1'b0, "b2b_pos15");
    endtask

    task automatic test_reset_mid();
        logic [15:0] cw;
        cw = 16'h8448;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            din = cw[i];
            din_valid = 1'b1;
        end
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({din_ready, dout_valid, stat_valid, err_corr, err_double} !== 5'b10000) begin
            n_err++;
            $display("FAIL midrst outputs: got %b%b%b%b%b want 10000", din_ready, dout_valid,
                     stat_valid, err_corr, err_double);
        end
        @(negedge clk);
        rst = 1'b0;
        send_block(16'h000F, 1'b0, 1'b0, 4'd0, 1'b1, "midrst");
        recv_block(11'h001, 1'b0, "midrst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
